// File: rtl/prirv32_pkg.sv
// Shared definitions for the prirv32 load/store path: access sizes, LSU
// state encoding and the default bus timeout.
package prirv32_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;

  localparam int unsigned LSU_BUS_TIMEOUT = 64;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

endpackage

// File: rtl/prirv32_lsu_align.sv
// Combinational byte-lane logic: misalignment check, store strobe/lane
// replication and load extraction with sign/zero extension.
module prirv32_lsu_align
  import prirv32_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        misalign_o,
  output logic [3:0]  strb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  assign shifted = rdata_i >> {addr_i, 3'b000};

  always_comb begin
    misalign_o = 1'b0;
    strb_o     = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = 32'h0;
    case (size_i)
      LSU_SIZE_B: begin
        strb_o  = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      LSU_SIZE_H: begin
        misalign_o = addr_i[0];
        strb_o     = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      LSU_SIZE_W: begin
        misalign_o = |addr_i;
        strb_o     = 4'b1111;
        rdata_o    = shifted;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/prirv32_lsu.sv
// Load/store unit: one outstanding access on a word-aligned bus, with
// misalignment and timeout detection and aligned load writeback.
module prirv32_lsu
  import prirv32_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = LSU_BUS_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [4:0]  req_rd_i,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        busy_o,
  output logic        err_misalign_o,
  output logic        err_timeout_o,
  output logic [31:0] err_addr_o
);

  localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d, err_addr_q, err_addr_d;
  logic [3:0]  strb_q, strb_d;
  logic [1:0]  size_q, size_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d, uns_q, uns_d, err_mis_q, err_mis_d, err_to_q, err_to_d;

  // In IDLE the aligner looks at the incoming request (results go only to
  // flops); afterwards it works from the latched request for load data.
  logic        idle, al_mis;
  logic [3:0]  al_strb;
  logic [31:0] al_wdata, al_rdata;
  assign idle = (state_q == LSU_IDLE);

  prirv32_lsu_align u_align (
    .addr_i     (idle ? req_addr_i[1:0] : addr_q[1:0]),
    .size_i     (idle ? req_size_i : size_q),
    .unsigned_i (idle ? req_unsigned_i : uns_q),
    .wdata_i    (req_wdata_i),
    .rdata_i    (bus_rdata_i),
    .misalign_o (al_mis),
    .strb_o     (al_strb),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    wb_data_d  = wb_data_q;
    err_addr_d = err_addr_q;
    cnt_d      = cnt_q;
    err_mis_d  = 1'b0;
    err_to_d   = 1'b0;
    case (state_q)
      LSU_IDLE: if (req_valid_i) begin
        if (al_mis) begin
          err_mis_d  = 1'b1;
          err_addr_d = req_addr_i;
        end else begin
          state_d = LSU_REQ;
          addr_d  = req_addr_i;
          wdata_d = al_wdata;
          strb_d  = req_we_i ? al_strb : 4'b0000;
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          rd_d    = req_rd_i;
          cnt_d   = 8'd0;
        end
      end
      LSU_REQ, LSU_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A completing event in the last allowed cycle beats the timeout.
        if (state_q == LSU_REQ && bus_ready_i) begin
          state_d = we_q ? LSU_IDLE : LSU_WAIT;
        end else if (state_q == LSU_WAIT && bus_rvalid_i) begin
          wb_data_d = al_rdata;
          state_d   = LSU_RESP;
        end else if (cnt_q == TO_LAST) begin
          state_d    = LSU_IDLE;
          err_to_d   = 1'b1;
          err_addr_d = addr_q;
        end
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= LSU_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      err_addr_q <= '0;
      cnt_q      <= '0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      wb_data_q  <= wb_data_d;
      err_addr_q <= err_addr_d;
      cnt_q      <= cnt_d;
      err_mis_q  <= err_mis_d;
      err_to_q   <= err_to_d;
    end
  end

  assign req_ready_o    = idle;
  assign busy_o         = ~idle;
  assign bus_valid_o    = (state_q == LSU_REQ);
  assign bus_addr_o     = {addr_q[31:2], 2'b00};
  assign bus_we_o       = we_q;
  assign bus_wstrb_o    = strb_q;
  assign bus_wdata_o    = wdata_q;
  assign wb_valid_o     = (state_q == LSU_RESP);
  assign wb_rd_o        = rd_q;
  assign wb_data_o      = wb_data_q;
  assign err_misalign_o = err_mis_q;
  assign err_timeout_o  = err_to_q;
  assign err_addr_o     = err_addr_q;

endmodule

// File: tb/tb_prirv32_lsu.sv
// Self-checking bench for prirv32_lsu: vector table plus timeout/reset sequences,
// with load writebacks checked against a scoreboard queue.
module tb_prirv32_lsu;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 0, req_we = 0, req_uns = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_size = 0;
  logic [4:0]  req_rd = 0;
  logic        bus_ready = 0, bus_rvalid = 0;
  logic [31:0] bus_rdata = 0;
  logic        req_ready, bus_valid, bus_we, wb_valid, busy, err_mis, err_to;
  logic [31:0] bus_addr, bus_wdata, wb_data, err_addr;
  logic [3:0]  bus_wstrb;
  logic [4:0]  wb_rd;

  int n_vec = 0, n_miss = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  always #5 clk = ~clk;

  prirv32_lsu #(.BUS_TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_we_i(req_we), .req_size_i(req_size),
    .req_unsigned_i(req_uns), .req_rd_i(req_rd),
    .bus_valid_o(bus_valid), .bus_ready_i(bus_ready), .bus_addr_o(bus_addr),
    .bus_we_o(bus_we), .bus_wstrb_o(bus_wstrb), .bus_wdata_o(bus_wdata),
    .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .busy_o(busy), .err_misalign_o(err_mis), .err_timeout_o(err_to),
    .err_addr_o(err_addr)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          stall;
    logic        mis;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_data;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(logic we, logic [1:0] sz, logic u, logic [31:0] a, logic [31:0] wd,
                               logic [4:0] rd, logic [31:0] rdat, int st, logic mis,
                               logic [3:0] strb, logic [31:0] ewd, logic [31:0] ed);
    vec_t v;
    v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.rd = rd; v.rdata = rdat;
    v.stall = st; v.mis = mis; v.e_strb = strb; v.e_wdata = ewd; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rst_chk(input string p);
    chk({p, "req_ready"}, req_ready, 1);   chk({p, "busy"}, busy, 0);
    chk({p, "bus_valid"}, bus_valid, 0);   chk({p, "bus_we"}, bus_we, 0);
    chk({p, "bus_wstrb"}, bus_wstrb, 0);   chk({p, "bus_addr"}, bus_addr, 0);
    chk({p, "bus_wdata"}, bus_wdata, 0);   chk({p, "wb_valid"}, wb_valid, 0);
    chk({p, "wb_data"}, wb_data, 0);       chk({p, "wb_rd"}, wb_rd, 0);
    chk({p, "err_mis"}, err_mis, 0);       chk({p, "err_to"}, err_to, 0);
    chk({p, "err_addr"}, err_addr, 0);
  endtask

  // Scoreboard: every writeback must match the oldest pending load.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wb_rd", wb_rd, mon_e[36:32]);
        chk("wb_data", wb_data, mon_e[31:0]);
      end
    end
  end

  task automatic drive_req(input logic we, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    req_we = we; req_size = sz; req_uns = u; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1;
  endtask

  task automatic scramble_req();
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_uns = 1'($urandom); req_rd = 5'($urandom); req_we = 1'($urandom);
  endtask

  task automatic apply(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d_", idx);
    chk({p, "ready_in"}, req_ready, 1);
    drive_req(v.we, v.size, v.uns, v.addr, v.wdata, v.rd);
    step();
    scramble_req();
    if (v.mis) begin
      chk({p, "mis_pulse"}, err_mis, 1);
      chk({p, "mis_addr"}, err_addr, v.addr);
      chk({p, "mis_nobus"}, bus_valid, 0);
      chk({p, "mis_ready"}, req_ready, 1);
      step();
      chk({p, "mis_clear"}, err_mis, 0);
      chk({p, "mis_nobus2"}, bus_valid, 0);
      return;
    end
    chk({p, "no_mis"}, err_mis, 0);
    for (int s = 0; s <= v.stall; s++) begin
      chk({p, "bus_valid"}, bus_valid, 1);
      chk({p, "bus_addr"}, bus_addr, {v.addr[31:2], 2'b00});
      chk({p, "bus_we"}, bus_we, v.we);
      if (v.we) begin
        chk({p, "bus_wstrb"}, bus_wstrb, v.e_strb);
        chk({p, "bus_wdata"}, bus_wdata, v.e_wdata);
      end
      chk({p, "ready_busy"}, req_ready, 0);
      bus_ready = (s == v.stall);
      // Read data before/at the handshake must be ignored.
      bus_rvalid = !v.we && v.stall > 0;
      bus_rdata = ~v.rdata;
      step();
    end
    bus_ready = 0; bus_rvalid = 0;
    chk({p, "bus_drop"}, bus_valid, 0);
    if (v.we) begin
      chk({p, "st_ready"}, req_ready, 1);
      return;
    end
    chk({p, "ld_wait_busy"}, busy, 1);
    bus_rvalid = 1; bus_rdata = v.rdata;
    exp_q.push_back({v.rd, v.e_data});
    step();
    bus_rvalid = 0; bus_rdata = $urandom;
    chk({p, "wb_valid"}, wb_valid, 1);
    step();
    chk({p, "wb_pulse"}, wb_valid, 0);
    chk({p, "ld_ready"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    //            we sz   u  addr          wdata         rd    rdata         st mis strb     ewdata        edata
    vt.push_back(mkv(0, 2'd0, 0, 32'h1003, 32'h0,        5'd5,  32'h80FF0000, 0, 0, 4'b0000, 32'h0,        32'hFFFFFF80));
    vt.push_back(mkv(0, 2'd1, 1, 32'h2002, 32'h0,        5'd6,  32'hBEEF1234, 1, 0, 4'b0000, 32'h0,        32'h0000BEEF));
    vt.push_back(mkv(0, 2'd2, 0, 32'h2000, 32'h0,        5'd7,  32'hBEEF1234, 0, 0, 4'b0000, 32'h0,        32'hBEEF1234));
    vt.push_back(mkv(0, 2'd1, 0, 32'h2002, 32'h0,        5'd8,  32'hBEEF1234, 0, 0, 4'b0000, 32'h0,        32'hFFFFBEEF));
    vt.push_back(mkv(0, 2'd0, 1, 32'h1001, 32'h0,        5'd9,  32'h12345678, 2, 0, 4'b0000, 32'h0,        32'h00000056));
    vt.push_back(mkv(0, 2'd0, 0, 32'h1002, 32'h0,        5'd10, 32'h12F45678, 0, 0, 4'b0000, 32'h0,        32'hFFFFFFF4));
    vt.push_back(mkv(0, 2'd2, 1, 32'h5000, 32'h0,        5'd0,  32'hCAFEF00D, 0, 0, 4'b0000, 32'h0,        32'hCAFEF00D));
    vt.push_back(mkv(0, 2'd1, 0, 32'h2000, 32'h0,        5'd11, 32'h00008001, 0, 0, 4'b0000, 32'h0,        32'hFFFF8001));
    vt.push_back(mkv(1, 2'd0, 0, 32'h3001, 32'hFFFFFFA5, 5'd0,  32'h0,        0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0));
    vt.push_back(mkv(1, 2'd1, 0, 32'h3002, 32'h00001234, 5'd0,  32'h0,        3, 0, 4'b1100, 32'h12341234, 32'h0));
    vt.push_back(mkv(1, 2'd2, 0, 32'h3004, 32'hDEADBEEF, 5'd0,  32'h0,        0, 0, 4'b1111, 32'hDEADBEEF, 32'h0));
    vt.push_back(mkv(1, 2'd0, 0, 32'h3000, 32'h00000077, 5'd0,  32'h0,        1, 0, 4'b0001, 32'h77777777, 32'h0));
    vt.push_back(mkv(1, 2'd1, 0, 32'h3000, 32'h5555ABCD, 5'd0,  32'h0,        0, 0, 4'b0011, 32'hABCDABCD, 32'h0));
    vt.push_back(mkv(1, 2'd0, 0, 32'h4003, 32'h0000003C, 5'd0,  32'h0,        0, 0, 4'b1000, 32'h3C3C3C3C, 32'h0));
    vt.push_back(mkv(0, 2'd2, 0, 32'h4002, 32'h0,        5'd1,  32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
    vt.push_back(mkv(0, 2'd3, 0, 32'h4000, 32'h0,        5'd1,  32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
    vt.push_back(mkv(0, 2'd1, 1, 32'h4001, 32'h0,        5'd1,  32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
    vt.push_back(mkv(1, 2'd2, 0, 32'h4001, 32'h0,        5'd0,  32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
    vt.push_back(mkv(1, 2'd1, 0, 32'h4003, 32'h0,        5'd0,  32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));

    repeat (3) @(posedge clk);
    #1;
    rst_chk("reset_");
    rst = 0;
    step();

    foreach (vt[i]) apply(vt[i], i);

    // Back-to-back misaligned requests, one per cycle.
    drive_req(0, 2'd2, 0, 32'h4002, 32'h0, 5'd1);
    step();
    chk("b2b_pulse0", err_mis, 1); chk("b2b_addr0", err_addr, 32'h4002); chk("b2b_ready0", req_ready, 1);
    drive_req(0, 2'd1, 0, 32'h4005, 32'h0, 5'd1);
    step();
    scramble_req();
    chk("b2b_pulse1", err_mis, 1); chk("b2b_addr1", err_addr, 32'h4005);
    step();
    chk("b2b_clear", err_mis, 0); chk("b2b_nobus", bus_valid, 0);

    // Load that never gets read data: timeout after 8 cycles in REQ+WAIT.
    drive_req(0, 2'd2, 0, 32'h6000, 32'h0, 5'd12);
    bus_ready = 1;
    step();                                       // cycle 1: REQ, handshake
    scramble_req();
    step();                                       // cycle 2: WAIT
    bus_ready = 0;
    cyc = 2;
    while (!err_to && cyc < 30) begin step(); cyc++; end
    chk("to_cycle", cyc, 9);
    chk("to_addr", err_addr, 32'h6000);
    chk("to_ready", req_ready, 1);
    chk("to_busy", busy, 0);
    chk("to_nowb", wb_valid, 0);
    bus_rvalid = 1; bus_rdata = 32'h11112222;     // late response
    step();
    bus_rvalid = 0;
    chk("to_pulse", err_to, 0);
    chk("late_nowb", wb_valid, 0);
    chk("late_idle", busy, 0);

    // Read data arriving in the last allowed cycle completes normally.
    drive_req(0, 2'd2, 0, 32'h6100, 32'h0, 5'd13);
    bus_ready = 1;
    step();
    scramble_req();
    step();
    bus_ready = 0;
    repeat (6) step();                            // cycle 8
    chk("edge_busy", busy, 1);
    bus_rvalid = 1; bus_rdata = 32'h0BADF00D;
    exp_q.push_back({5'd13, 32'h0BADF00D});
    step();
    bus_rvalid = 0;
    chk("edge_wb", wb_valid, 1);
    chk("edge_noto", err_to, 0);
    step();
    chk("edge_noto2", err_to, 0);
    chk("edge_ready", req_ready, 1);

    // Reset while waiting for read data.
    drive_req(0, 2'd2, 0, 32'h7000, 32'h0, 5'd14);
    bus_ready = 1;
    step();
    scramble_req();
    step();
    bus_ready = 0;
    chk("rw_wait", busy, 1);
    rst = 1;
    step();
    rst = 0;
    rst_chk("midrst_");
    bus_rvalid = 1; bus_rdata = 32'h33334444;     // stray response
    step();
    bus_rvalid = 0;
    chk("stray_nowb", wb_valid, 0);
    chk("stray_idle", busy, 0);
    step();
    chk("stray_nowb2", wb_valid, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/prirv32_lsu.md
# prirv32_lsu

Load/store unit sitting directly downstream of the execute stage. Accepts one memory request (address, store data, size, signedness, destination register) per handshake, drives a word-aligned data bus with byte strobes, then aligns and sign/zero-extends load data for register writeback. Detects misaligned accesses and bus timeouts, and stalls the core through `req_ready_o`/`busy_o` while a transaction is outstanding.

## Interface
- `BUS_TIMEOUT`, default 64: cycles allowed in REQ+WAIT before an access is abandoned; legal range 2..255.
- `clk_i  in  1`: clock; all state changes on its rising edge.
- `rst_i  in  1`: synchronous reset, active-high.
- `req_valid_i  in  1`: request present.
- `req_ready_o  out  1`: LSU can accept a request; high only in IDLE.
- `req_addr_i  in  32`: byte address computed by execute.
- `req_wdata_i  in  32`: store data, value in low bits.
- `req_we_i  in  1`: 1 = store, 0 = load.
- `req_size_i  in  2`: 0 byte, 1 half, 2 word; 3 illegal.
- `req_unsigned_i  in  1`: zero-extend the load (LBU/LHU).
- `req_rd_i  in  5`: load destination register.
- `bus_valid_o  out  1`, `bus_ready_i  in  1`: address-phase handshake.
- `bus_addr_o  out  32`: `{addr[31:2],2'b00}`.
- `bus_we_o  out  1`, `bus_wstrb_o  out  4`, `bus_wdata_o  out  32`: write controls and lane-replicated data.
- `bus_rvalid_i  in  1`, `bus_rdata_i  in  32`: read-data return.
- `wb_valid_o  out  1`, `wb_rd_o  out  5`, `wb_data_o  out  32`: load writeback, one-cycle pulse.
- `busy_o  out  1`: state is not IDLE.
- `err_misalign_o  out  1`, `err_timeout_o  out  1`: one-cycle error pulses.
- `err_addr_o  out  32`: byte address of the last faulting request; held until the next error.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: accept on `req_valid_i && req_ready_o`; latch all `req_*`.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0, or size 3): no bus access; next cycle pulse `err_misalign_o`, load `err_addr_o`, stay IDLE.
  - Otherwise go to REQ.
- REQ: `bus_valid_o`=1; addr/we/strb/wdata constant until `bus_ready_i`. On handshake: store → IDLE, load → WAIT.
- WAIT: on `bus_rvalid_i`, latch the extracted data → RESP.
- RESP: `wb_valid_o`=1 for one cycle with latched rd and data → IDLE. Loads to rd=0 still complete with `wb_valid_o` asserted; the consumer drops the write.
- Stores:
  - Byte: strobe `4'b0001<<addr[1:0]`, data `{4{b}}`.
  - Half: strobe 0011 or 1100 by addr[1], data `{2{h}}`.
  - Word: strobe 1111.
- Loads:
  - Shift `bus_rdata_i` right by `8*addr[1:0]`.
  - Take the low 8/16/32 bits.
  - Extend by `req_unsigned_i`, which is ignored for word.
- Timeout: a counter clears on entry to REQ and increments in REQ/WAIT. When it reaches `BUS_TIMEOUT` with no completing event that cycle: pulse `err_timeout_o`, load `err_addr_o`, go to IDLE, no writeback. A completion in the same cycle wins over timeout.
- `bus_rvalid_i` is ignored outside WAIT, including stray responses after a timeout or reset.

## Timing
- Reset values: state IDLE; `req_ready_o`=1; `busy_o`, `bus_valid_o`, `bus_we_o`, `wb_valid_o`, both error pulses = 0; `bus_wstrb_o`=0; `bus_addr_o`, `bus_wdata_o`, `wb_data_o`, `wb_rd_o`, `err_addr_o` = 0.
- All outputs are registered or decoded from state/latched registers; no combinational path from `req_*` to `bus_*`.
- Accept at cycle 0 → `bus_valid_o` at cycle 1.
- Load minimum: handshake at cycle 1, `rvalid` at cycle 2 (`rvalid` counts only in cycles after the handshake), `wb_valid_o` at cycle 3, `req_ready_o` at cycle 4.
- Store minimum: handshake at cycle 1, `req_ready_o` at cycle 2.
- Misaligned request: error pulse at cycle 1; `req_ready_o` stays high, so back-to-back requests are allowed.
- Reset mid-transaction: IDLE on the next edge, `bus_valid_o` drops, the pending result is discarded.

## Structure
- Shared package `prirv32_pkg`: size encodings `LSU_SIZE_B/H/W`, the LSU state encoding, and the `BUS_TIMEOUT` default.
- Sub-module `prirv32_lsu_align` (combinational):
  - Inputs: addr[1:0], size, unsigned.
  - Outputs: misalign flag, strobe, replicated write data, extracted/extended load data.
- FSM, timeout counter and latches live in the top.

## Test plan
- LB at 0x1003, rdata 0x80FF_0000, rd=5 → `bus_addr_o`=0x1000, `wb_data_o`=0xFFFF_FF80, `wb_rd_o`=5, `wb_valid_o` 3 cycles after accept.
- LHU at 0x2002, rdata 0xBEEF_1234 → `wb_data_o`=0x0000_BEEF. LW 0x2000 → 0xBEEF_1234.
- SB 0xA5 to 0x3001 → `bus_wstrb_o`=0010, `bus_wdata_o`=0xA5A5_A5A5. SH 0x1234 to 0x3002 → strb 1100, data 0x1234_1234. `bus_ready_i` held low 3 cycles → bus outputs stable; `req_ready_o` returns the cycle after the handshake.
- LW at 0x4002 → no `bus_valid_o`; `err_misalign_o` pulse at cycle 1 with `err_addr_o`=0x4002. Size 3 → same.
- Load with `bus_rvalid_i` never asserted, `BUS_TIMEOUT`=8 → `err_timeout_o` pulse, no `wb_valid_o`, IDLE. A late `rvalid` is ignored. `rvalid` on the timeout cycle → normal writeback, no error.
- `rst_i` asserted in WAIT → IDLE next cycle, all outputs at reset values, no writeback.
